// File: rtl/conv_layer_sequencer_if.sv
// Link between the layer sequencer and conv_controller plus pixel-source restart.
// master = sequencer side, slave = conv_controller side.
interface conv_layer_sequencer_if #(
  parameter int WT_ADDR_WIDTH   = 12,
  parameter int BIAS_ADDR_WIDTH = 7,
  parameter int CI_WIDTH        = 10
);
  logic                       cc_go;
  logic [CI_WIDTH-1:0]        cc_ci_groups;
  logic [BIAS_ADDR_WIDTH-1:0] cc_output_group;
  logic [WT_ADDR_WIDTH-1:0]   cc_wt_base_addr;
  logic                       cc_done;
  logic                       src_start;

  modport master (
    output cc_go, cc_ci_groups, cc_output_group, cc_wt_base_addr, src_start,
    input  cc_done
  );
  modport slave (
    input  cc_go, cc_ci_groups, cc_output_group, cc_wt_base_addr, src_start,
    output cc_done
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Layer-level scheduler: walks every output-channel group of a conv layer,
// programs conv_controller per group, replays the pixel frame, and reports
// completion / error status.
// Optional perf counters: define CONV_LAYER_SEQ_PERF_EN.
module conv_layer_sequencer #(
  parameter int WT_ADDR_WIDTH   = 12,
  parameter int BIAS_ADDR_WIDTH = 7,
  parameter int CI_WIDTH        = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CI_WIDTH-1:0]        cfg_ci_groups,
  input  logic [BIAS_ADDR_WIDTH:0]   cfg_co_groups,
  input  logic [WT_ADDR_WIDTH-1:0]   cfg_wt_base_addr,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 err_code,
  conv_layer_sequencer_if.master     cc,
  output logic [31:0]                perf_cycles,
  output logic [BIAS_ADDR_WIDTH:0]   perf_groups
);
  localparam int B = BIAS_ADDR_WIDTH;
  localparam int W = WT_ADDR_WIDTH;
  localparam logic [B:0] ONE = 1;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_DONE, NEXT} state_t;
  state_t state, state_d;

  logic [CI_WIDTH-1:0] ci_q;
  logic [B:0]          co_sh;
  logic [W-1:0]        base_sh, wt_q;
  logic [B-1:0]        grp_q;
  logic                abort_pend;

  logic       accept, cfg_bad, last_grp, fin, ld_first, ld_next;
  logic [1:0] fin_code;
  logic [W:0] next_base;

  assign accept    = (state == IDLE) && start && !abort;
  // zero groups, more groups than the bias index can address, or no input channels
  assign cfg_bad   = (co_sh == '0) || (co_sh[B] && (|co_sh[B-1:0])) || (ci_q == '0);
  assign last_grp  = ({1'b0, grp_q} == (co_sh - ONE));
  // one extra bit so a weight-address wrap shows up as a carry
  assign next_base = {1'b0, wt_q} + (W+1)'(ci_q);

  assign cc.cc_go           = (state == ISSUE);
  assign cc.src_start       = (state == ISSUE);
  assign cc.cc_ci_groups    = ci_q;
  assign cc.cc_output_group = grp_q;
  assign cc.cc_wt_base_addr = wt_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_d  = state;
    fin      = 1'b0;
    fin_code = 2'd0;
    ld_first = 1'b0;
    ld_next  = 1'b0;
    case (state)
      IDLE:      if (accept) state_d = CHECK;
      CHECK:     if (cfg_bad) begin fin = 1'b1; fin_code = 2'd1; end
                 else begin ld_first = 1'b1; state_d = ISSUE; end
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (cc.cc_done) begin
                   // the running group is always allowed to finish before an abort lands
                   if (abort_pend || abort) begin fin = 1'b1; fin_code = 2'd3; end
                   else if (last_grp)      fin = 1'b1;
                   else                    state_d = NEXT;
                 end
      NEXT:      if (next_base[W]) begin fin = 1'b1; fin_code = 2'd2; end
                 else begin ld_next = 1'b1; state_d = ISSUE; end
      default:   state_d = IDLE;
    endcase
    if (fin) state_d = IDLE;
  end

  // shadow config, status and per-group conv_controller programming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err_code   <= 2'd0;
      ci_q       <= '0;
      co_sh      <= '0;
      base_sh    <= '0;
      wt_q       <= '0;
      grp_q      <= '0;
      abort_pend <= 1'b0;
    end else begin
      done <= fin;
      if (accept) begin
        ci_q       <= cfg_ci_groups;
        co_sh      <= cfg_co_groups;
        base_sh    <= cfg_wt_base_addr;
        err_code   <= 2'd0;
        busy       <= 1'b1;
        abort_pend <= 1'b0;
      end else begin
        if (fin) begin
          busy     <= 1'b0;
          err_code <= fin_code;
        end
        if (state != IDLE && abort) abort_pend <= 1'b1;
      end
      if (ld_first) begin
        grp_q <= '0;
        wt_q  <= base_sh;
      end
      if (state == NEXT) grp_q <= grp_q + 1'b1;
      if (ld_next)       wt_q  <= next_base[W-1:0];
    end
  end

`ifdef CONV_LAYER_SEQ_PERF_EN
  // busy-cycle and completed-group counters, cleared on each accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_groups <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_groups <= '0;
    end else begin
      if (busy && perf_cycles != '1)      perf_cycles <= perf_cycles + 32'd1;
      if (state == WAIT_DONE && cc.cc_done) perf_groups <= perf_groups + ONE;
    end
  end
`else
  assign perf_cycles = '0;
  assign perf_groups = '0;
`endif
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: table of layer configs run against a
// conv_controller model, with a scoreboard of expected per-group programming.
`timescale 1ns/1ps
module tb_conv_layer_sequencer;
  localparam int WA = 12, BA = 7, CW = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [CW-1:0] cfg_ci = '0;
  logic [BA:0]   cfg_co = '0;
  logic [WA-1:0] cfg_base = '0;
  logic start = 1'b0, abort = 1'b0;
  logic busy, done;
  logic [1:0]  err_code;
  logic [31:0] perf_cycles;
  logic [BA:0] perf_groups;

  conv_layer_sequencer_if #(.WT_ADDR_WIDTH(WA), .BIAS_ADDR_WIDTH(BA), .CI_WIDTH(CW)) ifc ();

  conv_layer_sequencer #(.WT_ADDR_WIDTH(WA), .BIAS_ADDR_WIDTH(BA), .CI_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_ci_groups(cfg_ci), .cfg_co_groups(cfg_co), .cfg_wt_base_addr(cfg_base),
    .start(start), .abort(abort),
    .busy(busy), .done(done), .err_code(err_code),
    .cc(ifc),
    .perf_cycles(perf_cycles), .perf_groups(perf_groups)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct { logic [BA-1:0] grp; logic [WA-1:0] base; logic [CW-1:0] ci; } exp_go_t;
  exp_go_t sb[$];

  int cyc = 0, go_cnt = 0, done_cnt = 0, busy_cyc = 0, last_done = -1;
  int dly_cnt = 0, done_dly = 20;

  // conv_controller model + go monitor: done pulse done_dly cycles after each go
  always @(negedge clk) begin
    exp_go_t e;
    cyc++;
    if (!rst_n) begin
      dly_cnt     = 0;
      ifc.cc_done = 1'b0;
    end else begin
      ifc.cc_done = 1'b0;
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (ifc.cc_go || ifc.src_start) chk("src_start_eq_go", 32'(ifc.src_start), 32'(ifc.cc_go));
      if (ifc.cc_go) begin
        go_cnt++;
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_go: got cc_go group %0d, want no go", ifc.cc_output_group);
        end else begin
          e = sb.pop_front();
          chk("go_group", 32'(ifc.cc_output_group), 32'(e.grp));
          chk("go_base", 32'(ifc.cc_wt_base_addr), 32'(e.base));
          chk("go_ci", 32'(ifc.cc_ci_groups), 32'(e.ci));
        end
        if (last_done >= 0) chk("done_to_go", 32'(cyc - last_done), 32'd2);
        dly_cnt = done_dly;
      end else if (dly_cnt > 0) begin
        dly_cnt--;
        if (dly_cnt == 0) begin
          ifc.cc_done = 1'b1;
          last_done   = cyc;
        end
      end
    end
  end

  typedef struct { int ci; int co; int base; int dly; int abort_go; int exp_err; int exp_gos; string nm; } vec_t;
  vec_t tv[9];

  task automatic run(input vec_t v);
    int lat, ab;
    bit seen;
    cfg_ci = CW'(v.ci); cfg_co = (BA+1)'(v.co); cfg_base = WA'(v.base);
    done_dly = v.dly;
    go_cnt = 0; done_cnt = 0; busy_cyc = 0; last_done = -1;
    sb.delete();
    for (int g = 0; g < v.exp_gos; g++)
      sb.push_back('{grp: BA'(g), base: WA'(v.base + g * v.ci), ci: CW'(v.ci)});
    @(negedge clk);
    start = 1'b1;
    lat = 0; ab = 0; seen = 1'b0;
    while (!seen && lat < 20000) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (v.abort_go > 0 && go_cnt >= v.abort_go) ab++;
      abort = (ab == 5);
      if (done) seen = 1'b1;
    end
    abort = 1'b0;
    chk($sformatf("%s.done_seen", v.nm), 32'(seen), 32'd1);
    if (v.exp_err == 1) chk($sformatf("%s.bad_cfg_latency", v.nm), 32'(lat), 32'd2);
    chk($sformatf("%s.err_code", v.nm), 32'(err_code), 32'(v.exp_err));
    chk($sformatf("%s.busy_at_done", v.nm), 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk($sformatf("%s.go_count", v.nm), 32'(go_cnt), 32'(v.exp_gos));
    chk($sformatf("%s.done_count", v.nm), 32'(done_cnt), 32'd1);
    chk($sformatf("%s.sb_left", v.nm), 32'(sb.size()), 32'd0);
`ifdef CONV_LAYER_SEQ_PERF_EN
    chk($sformatf("%s.perf_groups", v.nm), 32'(perf_groups), 32'(v.exp_gos));
    chk($sformatf("%s.perf_cycles", v.nm), perf_cycles, 32'(busy_cyc));
`else
    chk($sformatf("%s.perf_groups", v.nm), 32'(perf_groups), 32'd0);
    chk($sformatf("%s.perf_cycles", v.nm), perf_cycles, 32'd0);
`endif
  endtask

  initial begin
    int n;
    //         ci    co   base   dly abort err gos  name
    tv[0] = '{4,    3,   'h100, 20,  0,   0,  3,   "norm3"};
    tv[1] = '{4,    0,   'h000, 20,  0,   1,  0,   "co_zero"};
    tv[2] = '{0,    3,   'h000, 20,  0,   1,  0,   "ci_zero"};
    tv[3] = '{1,    4,   'hFFE, 20,  0,   2,  2,   "wt_carry"};
    tv[4] = '{2,    5,   'h010, 20,  2,   3,  2,   "abort_g1"};
    tv[5] = '{3,    129, 'h000, 20,  0,   1,  0,   "co_too_big"};
    tv[6] = '{1,    128, 'h000, 2,   0,   0,  128, "co_max"};
    tv[7] = '{7,    2,   'h020, 10,  0,   0,  2,   "perf2"};
    tv[8] = '{1023, 1,   'hFFF, 5,   0,   0,  1,   "single_top"};

    // reset state
    #21;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err_code), 32'd0);
    chk("rst.go", 32'(ifc.cc_go), 32'd0);
    chk("rst.cfg_out", {ifc.cc_output_group, ifc.cc_wt_base_addr, ifc.cc_ci_groups}, 32'd0);
    chk("rst.perf", perf_cycles | 32'(perf_groups), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run(tv[i]);

    // start and abort together in IDLE: nothing happens
    go_cnt = 0; done_cnt = 0; sb.delete();
    cfg_ci = 10'd4; cfg_co = 8'd3; cfg_base = 12'h100;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (4) @(negedge clk);
    chk("start_abort.busy", 32'(busy), 32'd0);
    chk("start_abort.go", 32'(go_cnt), 32'd0);
    chk("start_abort.done", 32'(done_cnt), 32'd0);

    // async reset in the middle of WAIT_DONE
    done_dly = 20; go_cnt = 0; last_done = -1;
    sb.push_back('{grp: 7'd0, base: 12'h100, ci: 10'd4});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (go_cnt == 0 && n < 50) begin @(negedge clk); n++; end
    chk("mid_rst.first_go", 32'(go_cnt), 32'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.busy", 32'(busy), 32'd0);
    chk("mid_rst.cfg_out", {ifc.cc_output_group, ifc.cc_wt_base_addr, ifc.cc_ci_groups}, 32'd0);
    chk("mid_rst.go_err", {29'd0, ifc.cc_go, err_code}, 32'd0);
    chk("mid_rst.perf", perf_cycles | 32'(perf_groups), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(tv[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
